// File: rtl/proc_pkg.sv
// Shared types for the multi-cycle proc_core: FSM step encoding and opcode map.
// No logic here; imported by proc_ctrl and proc_core.
package proc_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [OPC_W-1:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MVNZ = 3'b110,
    OP_RSV  = 3'b111
  } opcode_t;

endpackage

// File: rtl/proc_ctrl.sv
// FSM + decode for proc_core: fetch in T0, 1 step for moves/illegal, 3 for ALU ops.
// No backpressure; Run is sampled only in T0. `PROC_EXT_OPS_EN enables AND/SLT/MVNZ.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int RSEL_W = 3,
  localparam int NUM_REGS = 2 ** RSEL_W
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    IR,
  input  logic                 Run,
  input  logic                 g_nz,
  output logic                 IR_in,
  output logic [NUM_REGS-1:0]  R_in,
  output logic [NUM_REGS-1:0]  R_out,
  output logic                 A_in,
  output logic                 G_in,
  output logic                 G_out,
  output logic                 DIN_out,
  output logic [OPC_W-1:0]     alu_op,
  output logic                 Done,
  output logic                 Illegal,
  output logic [1:0]           State
);

`ifdef PROC_EXT_OPS_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  opcode_t             opc;
  logic [RSEL_W-1:0]   rx, ry;

  assign opc    = opcode_t'(IR[DATA_W-1 -: OPC_W]);
  assign rx     = IR[2*RSEL_W-1 : RSEL_W];
  assign ry     = IR[RSEL_W-1 : 0];
  assign alu_op = IR[DATA_W-1 -: OPC_W];
  assign State  = state_q;

  always_comb begin
    state_d = state_q;
    IR_in   = 1'b0;
    R_in    = '0;
    R_out   = '0;
    A_in    = 1'b0;
    G_in    = 1'b0;
    G_out   = 1'b0;
    DIN_out = 1'b0;
    Done    = 1'b0;
    Illegal = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          IR_in   = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        case (opc)
          OP_MV: begin
            R_out[ry] = 1'b1;
            R_in[rx]  = 1'b1;
            Done      = 1'b1;
            state_d   = T0;
          end
          OP_MVI: begin
            DIN_out  = 1'b1;
            R_in[rx] = 1'b1;
            Done     = 1'b1;
            state_d  = T0;
          end
          OP_ADD, OP_SUB: begin
            R_out[rx] = 1'b1;
            A_in      = 1'b1;
            state_d   = T2;
          end
          OP_AND, OP_SLT: begin
            if (EXT_EN) begin
              R_out[rx] = 1'b1;
              A_in      = 1'b1;
              state_d   = T2;
            end else begin
              Done    = 1'b1;
              Illegal = 1'b1;
              state_d = T0;
            end
          end
          OP_MVNZ: begin
            Done    = 1'b1;
            state_d = T0;
            if (EXT_EN) begin
              R_out[ry] = 1'b1;
              R_in[rx]  = g_nz;
            end else begin
              Illegal = 1'b1;
            end
          end
          default: begin
            Done    = 1'b1;
            Illegal = 1'b1;
            state_d = T0;
          end
        endcase
      end
      // T2/T3 are only reachable through an ALU opcode, so no re-decode here.
      T2: begin
        R_out[ry] = 1'b1;
        G_in      = 1'b1;
        state_d   = T3;
      end
      T3: begin
        G_out    = 1'b1;
        R_in[rx] = 1'b1;
        Done     = 1'b1;
        state_d  = T0;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) state_q <= T0;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/proc_core.sv
// Register-file processor core: register file, ALU and shared bus around proc_ctrl.
// Latency 1 (MV/MVI/MVNZ/illegal) or 3 (ALU) cycles after fetch; no backpressure. `PROC_EXT_OPS_EN.
module proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int RSEL_W = 3,
  localparam int NUM_REGS = 2 ** RSEL_W
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic                          Run,
  input  logic [DATA_W-1:0]             DIN,
  output logic                          Done,
  output logic [DATA_W-1:0]             Bus,
  output logic [1:0]                    State,
  output logic [DATA_W-1:0]             IR,
  output logic [DATA_W-1:0]             regA,
  output logic [DATA_W-1:0]             regG,
  output logic [NUM_REGS*DATA_W-1:0]    R_flat,
  output logic                          Ovf,
  output logic                          Illegal
);

  logic [DATA_W-1:0]    r_q [NUM_REGS];
  logic [DATA_W-1:0]    ir_q, a_q, g_q, g_d, b_eff;
  logic                 ovf_q, ovf_d;
  logic                 ir_in, a_in, g_in, g_out, din_out;
  logic [NUM_REGS-1:0]  r_in, r_out;
  logic [OPC_W-1:0]     alu_op;

  proc_ctrl #(
    .DATA_W (DATA_W),
    .RSEL_W (RSEL_W)
  ) u_ctrl (
    .clk_50  (clk_50),
    .reset   (reset),
    .IR      (ir_q),
    .Run     (Run),
    .g_nz    (|g_q),
    .IR_in   (ir_in),
    .R_in    (r_in),
    .R_out   (r_out),
    .A_in    (a_in),
    .G_in    (g_in),
    .G_out   (g_out),
    .DIN_out (din_out),
    .alu_op  (alu_op),
    .Done    (Done),
    .Illegal (Illegal),
    .State   (State)
  );

  // Register sources are one-hot, so an OR-reduce suffices for the bus mux.
  always_comb begin
    Bus = '0;
    if (din_out)    Bus = DIN;
    else if (g_out) Bus = g_q;
    else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_out[i]) Bus = Bus | r_q[i];
      end
    end
  end

  always_comb begin
    b_eff = (alu_op == OP_SUB) ? ~Bus : Bus;
    case (alu_op)
      OP_ADD:  g_d = a_q + Bus;
      OP_SUB:  g_d = a_q - Bus;
      OP_AND:  g_d = a_q & Bus;
      OP_SLT:  g_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(Bus))};
      default: g_d = '0;
    endcase
    ovf_d = (a_q[DATA_W-1] == b_eff[DATA_W-1]) && (g_d[DATA_W-1] != a_q[DATA_W-1]);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      ir_q  <= '0;
      a_q   <= '0;
      g_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
    end else begin
      if (ir_in) ir_q <= DIN;
      if (a_in)  a_q  <= Bus;
      if (g_in) begin
        g_q <= g_d;
        if (alu_op == OP_ADD || alu_op == OP_SUB) ovf_q <= ovf_d;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_in[i]) r_q[i] <= Bus;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign R_flat[i*DATA_W +: DATA_W] = r_q[i];
  end

  assign IR   = ir_q;
  assign regA = a_q;
  assign regG = g_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_proc_core.sv
// Directed vector bench for proc_core (DATA_W=9, RSEL_W=3); extended ops under PROC_EXT_OPS_EN.
module tb_proc_core;

  logic        clk_50 = 1'b0;
  logic        reset, Run;
  logic [8:0]  DIN;
  logic        Done, Ovf, Illegal;
  logic [8:0]  Bus, IR, regA, regG;
  logic [1:0]  State;
  logic [71:0] R_flat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] mdl [8];

  typedef struct {
    logic [8:0] ins;
    logic [8:0] imm;
    int         dst;
    bit         wr;
    logic [8:0] val;
    int         cyc;
    bit         ill;
    bit         ovf;
  } vec_t;

  vec_t vecs[$];

  proc_core dut (
    .clk_50  (clk_50),
    .reset   (reset),
    .Run     (Run),
    .DIN     (DIN),
    .Done    (Done),
    .Bus     (Bus),
    .State   (State),
    .IR      (IR),
    .regA    (regA),
    .regG    (regG),
    .R_flat  (R_flat),
    .Ovf     (Ovf),
    .Illegal (Illegal)
  );

  always #5 clk_50 = ~clk_50;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] mflat();
    logic [71:0] r;
    for (int i = 0; i < 8; i++) r[i*9 +: 9] = mdl[i];
    return r;
  endfunction

  task automatic add(input logic [8:0] ins, input logic [8:0] imm, input int dst, input bit wr,
                     input logic [8:0] val, input int cyc, input bit ill, input bit ovf);
    vec_t v;
    v.ins = ins; v.imm = imm; v.dst = dst; v.wr = wr;
    v.val = val; v.cyc = cyc; v.ill = ill; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  // Fetch one instruction, count cycles to Done (bounded), then settle back in T0.
  task automatic exec(input logic [8:0] ins, input logic [8:0] imm, output int cyc, output logic ill);
    @(negedge clk_50);
    Run = 1'b1;
    DIN = ins;
    @(negedge clk_50);
    Run = 1'b0;
    DIN = imm;
    cyc = 1;
    while (Done !== 1'b1 && cyc < 8) begin
      @(negedge clk_50);
      cyc++;
    end
    ill = Illegal;
    @(negedge clk_50);
  endtask

  initial begin
    int   cyc;
    logic ill;

    // Reset held with Run high: reset must win and IR must stay clear.
    reset = 1'b1;
    Run   = 1'b1;
    DIN   = 9'h1FF;
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    Run   = 1'b0;
    DIN   = 9'h000;
    for (int i = 0; i < 8; i++) mdl[i] = 9'h000;
    chk("rst State", State, 2'd0);
    chk("rst IR", IR, 9'h000);
    chk("rst regA", regA, 9'h000);
    chk("rst regG", regG, 9'h000);
    chk("rst R_flat", R_flat, 72'h0);
    chk("rst Ovf", Ovf, 1'b0);
    chk("rst Done", Done, 1'b0);
    chk("rst Illegal", Illegal, 1'b0);
    chk("rst Bus", Bus, 9'h000);

    //   ins      imm     dst wr val     cyc ill ovf
    add(9'h040, 9'h005, 0, 1, 9'h005, 1, 0, 0);   // MVI R0,5
    add(9'h048, 9'h003, 1, 1, 9'h003, 1, 0, 0);   // MVI R1,3
    add(9'h081, 9'h000, 0, 1, 9'h008, 3, 0, 0);   // ADD R0,R1
    add(9'h0C9, 9'h000, 1, 1, 9'h000, 3, 0, 0);   // SUB R1,R1
    add(9'h040, 9'h0FF, 0, 1, 9'h0FF, 1, 0, 0);   // MVI R0,0FF
    add(9'h080, 9'h000, 0, 1, 9'h1FE, 3, 0, 1);   // ADD R0,R0
    add(9'h050, 9'h100, 2, 1, 9'h100, 1, 0, 1);   // MVI R2,100
    add(9'h058, 9'h001, 3, 1, 9'h001, 1, 0, 1);   // MVI R3,1
    add(9'h0D3, 9'h000, 2, 1, 9'h0FF, 3, 0, 1);   // SUB R2,R3
    add(9'h02A, 9'h000, 5, 1, 9'h0FF, 1, 0, 1);   // MV R5,R2
    add(9'h1C1, 9'h000, 0, 0, 9'h000, 1, 1, 1);   // opcode 111
`ifdef PROC_EXT_OPS_EN
    add(9'h058, 9'h1FF, 3, 1, 9'h1FF, 1, 0, 1);   // MVI R3,1FF
    add(9'h060, 9'h001, 4, 1, 9'h001, 1, 0, 1);   // MVI R4,1
    add(9'h15C, 9'h000, 3, 1, 9'h001, 3, 0, 1);   // SLT R3,R4
    add(9'h070, 9'h0F0, 6, 1, 9'h0F0, 1, 0, 1);   // MVI R6,0F0
    add(9'h078, 9'h03C, 7, 1, 9'h03C, 1, 0, 1);   // MVI R7,03C
    add(9'h137, 9'h000, 6, 1, 9'h030, 3, 0, 1);   // AND R6,R7
    add(9'h1BD, 9'h000, 7, 1, 9'h0FF, 1, 0, 1);   // MVNZ R7,R5 (G!=0)
    add(9'h111, 9'h000, 2, 1, 9'h000, 3, 0, 1);   // AND R2,R1 -> G=0
    add(9'h1BE, 9'h000, 7, 0, 9'h000, 1, 0, 1);   // MVNZ R7,R6 (G==0)
`else
    add(9'h101, 9'h000, 0, 0, 9'h000, 1, 1, 1);   // opcode 100 disabled
    add(9'h1BE, 9'h000, 7, 0, 9'h000, 1, 1, 1);   // opcode 110 disabled
`endif

    foreach (vecs[i]) begin
      exec(vecs[i].ins, vecs[i].imm, cyc, ill);
      if (vecs[i].wr) mdl[vecs[i].dst] = vecs[i].val;
      chk($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d Illegal", i), ill, vecs[i].ill);
      chk($sformatf("v%0d Ovf", i), Ovf, vecs[i].ovf);
      chk($sformatf("v%0d R_flat", i), R_flat, mflat());
      chk($sformatf("v%0d State", i), State, 2'd0);
    end

    // Reset in T2 of ADD R0,R1: aborts without a write and clears everything.
    @(negedge clk_50);
    Run = 1'b1;
    DIN = 9'h081;
    @(negedge clk_50);
    Run = 1'b0;
    chk("abort T1", State, 2'd1);
    @(negedge clk_50);
    chk("abort T2", State, 2'd2);
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 9'h000;
    chk("abort State", State, 2'd0);
    chk("abort R_flat", R_flat, mflat());
    chk("abort regA", regA, 9'h000);
    chk("abort regG", regG, 9'h000);
    chk("abort Ovf", Ovf, 1'b0);
    chk("abort Done", Done, 1'b0);

    // Run held high: MVI R1,7; MV R2,R1; ADD R2,R1 with no idle T0 between them.
    @(negedge clk_50);
    Run = 1'b1;
    DIN = 9'h048;
    @(negedge clk_50);
    DIN = 9'h007;
    #1;
    chk("b2b mvi T1", State, 2'd1);
    chk("b2b mvi Done", Done, 1'b1);
    chk("b2b mvi Bus", Bus, 9'h007);
    @(negedge clk_50);
    chk("b2b fetch2 T0", State, 2'd0);
    DIN = 9'h011;
    @(negedge clk_50);
    chk("b2b mv T1", State, 2'd1);
    chk("b2b mv Done", Done, 1'b1);
    chk("b2b R1", R_flat[9 +: 9], 9'h007);
    @(negedge clk_50);
    chk("b2b fetch3 T0", State, 2'd0);
    chk("b2b R2 mv", R_flat[18 +: 9], 9'h007);
    DIN = 9'h091;
    @(negedge clk_50);
    chk("b2b add T1", State, 2'd1);
    chk("b2b add T1 Done", Done, 1'b0);
    @(negedge clk_50);
    chk("b2b add T2", State, 2'd2);
    @(negedge clk_50);
    chk("b2b add T3", State, 2'd3);
    chk("b2b add Done", Done, 1'b1);
    chk("b2b add Bus", Bus, 9'h00E);
    Run = 1'b0;
    @(negedge clk_50);
    chk("b2b end T0", State, 2'd0);
    chk("b2b R2 add", R_flat[18 +: 9], 9'h00E);
    chk("b2b IR held", IR, 9'h091);
    @(negedge clk_50);
    chk("b2b idle", State, 2'd0);
    chk("b2b idle Bus", Bus, 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_core.md
# proc_core

Parametrised multi-cycle register-file processor core. Fetches one instruction word from `DIN` on a `Run` request, then executes it over 1–3 further cycles across a shared internal bus. It supports MV, MVI, ADD and SUB, plus optional AND, SLT and MVNZ, with signed-overflow and illegal-opcode reporting. It is the next-generation datapath for the lab processor designs and is configurable in data width and register count.

## Interface
- `DATA_W`, default 9: data, bus, register and instruction width. Must be ≥ 3 + 2·`RSEL_W`.
- `RSEL_W`, default 3: register-select field width. `NUM_REGS` = 2^`RSEL_W`.
- `clk_50`, input, 1: sole clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `Run`, input, 1: start request, sampled only in T0.
- `DIN`, input, `DATA_W`: instruction word in T0; immediate data in T1 of MVI.
- `Done`, output, 1: high during the final cycle of every instruction.
- `Bus`, output, `DATA_W`: internal bus value.
- `State`, output, 2: current step, T0=0 … T3=3.
- `IR`, `regA`, `regG`, output, `DATA_W` each: visible internal registers.
- `R_flat`, output, `NUM_REGS`·`DATA_W`: register file; R*i* occupies bits [i·`DATA_W` +: `DATA_W`].
- `Ovf`, output, 1: registered signed-overflow flag of the last ADD/SUB.
- `Illegal`, output, 1: high with `Done` when the opcode is not implemented.

## Operation
- **Instruction encoding:**
  - opcode = `IR`[`DATA_W`-1 -: 3]
  - X = `IR`[2·`RSEL_W`-1 : `RSEL_W`]
  - Y = `IR`[`RSEL_W`-1 : 0]
  - Remaining bits are ignored.
- **Opcodes:**
  - 000 MV: Rx ← Ry
  - 001 MVI: Rx ← `DIN`
  - 010 ADD: Rx ← Rx + Ry
  - 011 SUB: Rx ← Rx − Ry
  - 100 AND: Rx ← Rx & Ry
  - 101 SLT: Rx ← (Rx <ₛ Ry) ? 1 : 0
  - 110 MVNZ: if `regG` ≠ 0 then Rx ← Ry
  - 111: reserved
- **FSM:**
  - T0: `IR` ← `DIN` when `Run`=1, then go to T1. Otherwise stay in T0 with `IR` held.
  - T1:
    - MV: `Bus` = Ry, Rx ← `Bus`, `Done`=1, go to T0.
    - MVI: `Bus` = `DIN`, Rx ← `Bus`, `Done`=1, go to T0.
    - MVNZ: `Bus` = Ry, Rx ← `Bus` only if `regG` ≠ 0, `Done`=1, go to T0.
    - ALU ops: `Bus` = Rx, `regA` ← `Bus`, go to T2.
    - Reserved/disabled opcodes: `Done`=1, `Illegal`=1, no register writes, go to T0.
  - T2 (ALU ops): `Bus` = Ry, `regG` ← f(`regA`, `Bus`). For ADD/SUB, `Ovf` ← signed overflow. Go to T3.
  - T3: `Bus` = `regG`, Rx ← `Bus`, `Done`=1, go to T0.
- **Arithmetic:** all results are modulo 2^`DATA_W`. The carry-out is discarded. Ovf = (sign A == sign B′) & (sign result ≠ sign A), where B′ is Ry for ADD and ~Ry for SUB. AND and SLT leave `Ovf` unchanged.
- **Bus:** driven 0 in T0 and in any state/opcode without a defined source.
- **Run and back-to-back:** `Run` outside T0 is ignored. With `Run` held high, the next instruction is fetched in the T0 cycle that immediately follows `Done`.
- **X == Y:** legal. ADD R0,R0 doubles R0.

## Timing
- **Reset (`reset`=1 at an edge):**
  - State → T0.
  - `IR`, `regA`, `regG`, all Ri, `Ovf` → 0.
  - `Done`, `Illegal` = 0 and `Bus` = 0 after reset.
  - Reset dominates `Run`.
  - Reset mid-instruction aborts it; no destination write occurs.
- **Latency**, counted from the T0 edge that samples `Run`=1:
  - MV, MVI, MVNZ and illegal opcodes: 1 cycle. `Done` is high in the cycle after the fetch edge, and Rx updates at the next edge.
  - ALU ops: 3 cycles. Rx updates at the edge closing T3.
- **Output types:** `Done`, `Illegal` and `Bus` are combinational from state and `IR`. All other outputs are registered.

## Configuration
- `PROC_EXT_OPS_EN` defined: AND, SLT and MVNZ are implemented as above.
- Undefined: opcodes 100–111 all take the illegal path (T1 `Done` + `Illegal`, no writes). Only MV, MVI, ADD and SUB remain.

## Structure
- **Package `proc_pkg`:**
  - `state_t` enum T0–T3 (2 bits)
  - `opcode_t` enum of the 8 opcodes
  - `OPC_W` = 3
- **Sub-module `proc_ctrl`:** the FSM plus decode. Inputs are `IR`, `Run`, `regG`-nonzero, `clk_50` and `reset`. Outputs are register-in/out one-hot enables, `A_in`, `G_in`, `G_out`, `DIN_out`, ALU op select, `Done`, `Illegal` and `State`.
- **`proc_core`:** holds the register file, ALU and bus mux.

## Test plan
- MVI R0,5 then MVI R1,3, then ADD R0,R1 → R0=8. `Done` high in T3 only; 3 cycles from the fetch edge; `Ovf`=0.
- R0=0x0FF, ADD R0,R0 (`DATA_W`=9) → R0=0x1FE, `Ovf`=1. R2=0x100, R3=1, SUB R2,R3 → R2=0x0FF, `Ovf`=1.
- With `PROC_EXT_OPS_EN` defined:
  - R3=0x1FF, R4=1, SLT R3,R4 → R3=1.
  - AND 0x0F0 & 0x03C → 0x030.
  - MVNZ with `regG`=0 → Rx unchanged; with `regG`≠0 → Rx=Ry.
- Opcode 111, and opcode 100 without `PROC_EXT_OPS_EN` → `Done`=`Illegal`=1 in T1, all registers unchanged, back in T0.
- `reset` asserted in T2 of ADD → next cycle in T0, all registers 0, no write.
- `Run` held high over MV, MVI, ADD → instructions execute back-to-back. The T0 fetch follows each `Done` with no idle gap.
